// File: rtl/sdf_bfly_stage.sv
// Radix-2 single-path delay-feedback butterfly stage: buffers half a block,
// emits sums in BFLY and twiddle-multiplied stored differences in TWID.
module sdf_bfly_stage #(
  parameter int unsigned DATA_W = 24,
  parameter int unsigned FRAC_W = 8,
  parameter int unsigned DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] din_r,
  input  logic [DATA_W-1:0] din_i,
  input  logic [1:0]        state,
  input  logic [DATA_W-1:0] w_r,
  input  logic [DATA_W-1:0] w_i,
  output logic              out_valid,
  output logic [DATA_W-1:0] dout_r,
  output logic [DATA_W-1:0] dout_i
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned ProdW = 2 * DATA_W;

  typedef enum logic [1:0] {
    StFill = 2'd0,
    StBfly = 2'd1,
    StTwid = 2'd2,
    StRsvd = 2'd3
  } phase_e;

  logic [PtrW-1:0]   ptr;
  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [DATA_W-1:0] mem_i [DEPTH];

  logic [DATA_W-1:0] cur_r, cur_i;
  logic [DATA_W-1:0] sum_r, sum_i, dif_r, dif_i;
  logic [DATA_W-1:0] mul_r, mul_i;
  logic signed [ProdW-1:0] p_rr, p_ii, p_ri, p_ir, acc_r, acc_i;
  logic unused_prod_bits;
  phase_e phase;

  assign phase = phase_e'(state);
  assign cur_r = mem_r[ptr];
  assign cur_i = mem_i[ptr];

  always_comb begin
    sum_r = cur_r + din_r;
    sum_i = cur_i + din_i;
    dif_r = cur_r - din_r;
    dif_i = cur_i - din_i;
  end

  // Full-width signed products; the kept slice equals (acc >>> FRAC_W) truncated to DATA_W.
  always_comb begin
    p_rr  = ProdW'($signed(cur_r)) * ProdW'($signed(w_r));
    p_ii  = ProdW'($signed(cur_i)) * ProdW'($signed(w_i));
    p_ri  = ProdW'($signed(cur_r)) * ProdW'($signed(w_i));
    p_ir  = ProdW'($signed(cur_i)) * ProdW'($signed(w_r));
    acc_r = p_rr - p_ii;
    acc_i = p_ri + p_ir;
    mul_r = acc_r[FRAC_W +: DATA_W];
    mul_i = acc_i[FRAC_W +: DATA_W];
  end

  assign unused_prod_bits = ^{acc_r[FRAC_W-1:0], acc_r[ProdW-1:FRAC_W+DATA_W],
                              acc_i[FRAC_W-1:0], acc_i[ProdW-1:FRAC_W+DATA_W]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr       <= '0;
      out_valid <= 1'b0;
      dout_r    <= '0;
      dout_i    <= '0;
      for (int k = 0; k < int'(DEPTH); k++) begin
        mem_r[k] <= '0;
        mem_i[k] <= '0;
      end
    end else if (in_valid) begin
      ptr <= (ptr == PtrW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
      case (phase)
        StBfly: begin
          dout_r     <= sum_r;
          dout_i     <= sum_i;
          mem_r[ptr] <= dif_r;
          mem_i[ptr] <= dif_i;
          out_valid  <= 1'b1;
        end
        StTwid: begin
          dout_r     <= mul_r;
          dout_i     <= mul_i;
          mem_r[ptr] <= din_r;
          mem_i[ptr] <= din_i;
          out_valid  <= 1'b1;
        end
        default: begin
          // FILL and the reserved code both just load the buffer.
          mem_r[ptr] <= din_r;
          mem_i[ptr] <= din_i;
          out_valid  <= 1'b0;
        end
      endcase
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sdf_bfly_stage.sv
// Directed bench for sdf_bfly_stage (DEPTH=2, Q16.8): vector table plus
// hand-written reset, post-reset and stall sequences.
module tb_sdf_bfly_stage;

  localparam int unsigned DW = 24;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic [DW-1:0] din_r, din_i, w_r, w_i;
  logic [1:0]    state;
  logic          out_valid;
  logic [DW-1:0] dout_r, dout_i;

  int checks;
  int failures;

  sdf_bfly_stage #(
    .DATA_W(24),
    .FRAC_W(8),
    .DEPTH (2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .din_r    (din_r),
    .din_i    (din_i),
    .state    (state),
    .w_r      (w_r),
    .w_i      (w_i),
    .out_valid(out_valid),
    .dout_r   (dout_r),
    .dout_i   (dout_i)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic          v;
    logic [DW-1:0] dr;
    logic [DW-1:0] di;
    logic [1:0]    st;
    logic [DW-1:0] wr;
    logic [DW-1:0] wi;
    logic          ev;
    logic [DW-1:0] er;
    logic [DW-1:0] ei;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %06h expected %06h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the rising edge.
  task automatic step(input logic v, input logic [DW-1:0] dr, input logic [DW-1:0] di,
                      input logic [1:0] st, input logic [DW-1:0] wr, input logic [DW-1:0] wi);
    in_valid = v;
    din_r    = dr;
    din_i    = di;
    state    = st;
    w_r      = wr;
    w_i      = wi;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic ev, input logic [DW-1:0] er,
                            input logic [DW-1:0] ei);
    check({tag, " out_valid"}, {23'd0, out_valid}, {23'd0, ev});
    check({tag, " dout_r"}, dout_r, er);
    check({tag, " dout_i"}, dout_i, ei);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    din_r = '0; din_i = '0; state = 2'd0; w_r = '0; w_i = '0;

    //            v  din_r      din_i      st    w_r        w_i        ev  exp_r      exp_i
    vecs[0]  = '{1'b1, 24'h000100, 24'h0, 2'd0, 24'h0, 24'h0, 1'b0, 24'h0, 24'h0};
    vecs[1]  = '{1'b1, 24'h000200, 24'h0, 2'd0, 24'h0, 24'h0, 1'b0, 24'h0, 24'h0};
    vecs[2]  = '{1'b1, 24'h000300, 24'h0, 2'd1, 24'h0, 24'h0, 1'b1, 24'h000400, 24'h0};
    vecs[3]  = '{1'b1, 24'h000400, 24'h0, 2'd1, 24'h0, 24'h0, 1'b1, 24'h000600, 24'h0};
    vecs[4]  = '{1'b1, 24'h000500, 24'h0, 2'd2, 24'h000100, 24'h0, 1'b1, 24'hFFFE00, 24'h0};
    vecs[5]  = '{1'b1, 24'h000600, 24'h0, 2'd2, 24'h0, 24'hFFFF00, 1'b1, 24'h0, 24'h000200};
    // Next frame: first half was refilled during TWID above.
    vecs[6]  = '{1'b1, 24'h000100, 24'h000100, 2'd1, 24'h0, 24'h0, 1'b1, 24'h000600, 24'h000100};
    vecs[7]  = '{1'b0, 24'h0, 24'h0, 2'd1, 24'h0, 24'h0, 1'b0, 24'h000600, 24'h000100};
    vecs[8]  = '{1'b1, 24'h000700, 24'h0, 2'd1, 24'h0, 24'h0, 1'b1, 24'h000D00, 24'h0};
    vecs[9]  = '{1'b1, 24'h0, 24'h0, 2'd2, 24'h000100, 24'h000100, 1'b1, 24'h000500, 24'h000300};
    vecs[10] = '{1'b1, 24'h0, 24'h0, 2'd2, 24'h000100, 24'h0, 1'b1, 24'hFFFF00, 24'h0};
    // Reserved state loads like FILL; then overflow wrap in BFLY.
    vecs[11] = '{1'b1, 24'h7FFF00, 24'h0, 2'd3, 24'h0, 24'h0, 1'b0, 24'hFFFF00, 24'h0};
    vecs[12] = '{1'b1, 24'h000123, 24'h0, 2'd0, 24'h0, 24'h0, 1'b0, 24'hFFFF00, 24'h0};
    vecs[13] = '{1'b1, 24'h000200, 24'h0, 2'd1, 24'h0, 24'h0, 1'b1, 24'h800100, 24'h0};
    vecs[14] = '{1'b1, 24'h000023, 24'h0, 2'd1, 24'h0, 24'h0, 1'b1, 24'h000146, 24'h0};
    vecs[15] = '{1'b1, 24'h0, 24'h0, 2'd2, 24'h000100, 24'h0, 1'b1, 24'h7FFD00, 24'h0};
    vecs[16] = '{1'b1, 24'h0, 24'h0, 2'd2, 24'h000100, 24'h0, 1'b1, 24'h000100, 24'h0};
    // Floor rounding: -1 LSB times 0.5 stays -1 LSB.
    vecs[17] = '{1'b1, 24'hFFFFFF, 24'h0, 2'd0, 24'h0, 24'h0, 1'b0, 24'h000100, 24'h0};
    vecs[18] = '{1'b1, 24'h0, 24'h0, 2'd0, 24'h0, 24'h0, 1'b0, 24'h000100, 24'h0};
    vecs[19] = '{1'b1, 24'h0, 24'h0, 2'd2, 24'h000080, 24'h0, 1'b1, 24'hFFFFFF, 24'h0};

    #12;
    expect_out("reset", 1'b0, 24'h0, 24'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      step(vecs[i].v, vecs[i].dr, vecs[i].di, vecs[i].st, vecs[i].wr, vecs[i].wi);
      expect_out($sformatf("vec%0d", i), vecs[i].ev, vecs[i].er, vecs[i].ei);
    end

    // Asynchronous reset mid-stream, checked before the next clock edge.
    in_valid = 1'b1; din_r = 24'h000300; state = 2'd1;
    #2;
    rst_n = 1'b0;
    #1;
    expect_out("async_rst", 1'b0, 24'h0, 24'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 24'h0, 24'h0, 2'd0, 24'h0, 24'h0);
      expect_out($sformatf("idle%0d", i), 1'b0, 24'h0, 24'h0);
    end
    // First butterfly after reset sees zeroed buffer entries.
    step(1'b1, 24'h000300, 24'h0, 2'd1, 24'h0, 24'h0);
    expect_out("post_rst_bfly", 1'b1, 24'h000300, 24'h0);

    // Stall between BFLY samples must not disturb results.
    do_reset();
    step(1'b1, 24'h000100, 24'h0, 2'd0, 24'h0, 24'h0);
    step(1'b1, 24'h000200, 24'h0, 2'd0, 24'h0, 24'h0);
    step(1'b1, 24'h000300, 24'h0, 2'd1, 24'h0, 24'h0);
    expect_out("stall_b0", 1'b1, 24'h000400, 24'h0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 24'h0, 24'h0, 2'd1, 24'h0, 24'h0);
      expect_out($sformatf("stall_gap%0d", i), 1'b0, 24'h000400, 24'h0);
    end
    step(1'b1, 24'h000400, 24'h0, 2'd1, 24'h0, 24'h0);
    expect_out("stall_b1", 1'b1, 24'h000600, 24'h0);
    step(1'b1, 24'h000500, 24'h0, 2'd2, 24'h000100, 24'h0);
    expect_out("stall_t0", 1'b1, 24'hFFFE00, 24'h0);
    step(1'b1, 24'h000600, 24'h0, 2'd2, 24'h0, 24'hFFFF00);
    expect_out("stall_t1", 1'b1, 24'h0, 24'h000200);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
